// File: rtl/step_sequencer.sv
// step_sequencer: STEPS-deep note pattern player with play/pause/stop control,
// loop or one-shot mode, per-step gate length and a square-wave tone output.
//
// Ports:
//   CLOCK_50     in   system clock
//   rst          in   synchronous active-high reset
//   play         in   1-cycle pulse: start / pause / resume
//   stop         in   1-cycle pulse: stop and rewind (wins over play)
//   loop_mode    in   1 = wrap after last step, 0 = one-shot
//   wr_en        in   pattern write strobe
//   wr_addr      in   step index to write (>= STEPS ignored)
//   wr_note      in   3-bit note code (C4..C5)
//   wr_rest      in   1 = step is silent
//   step_idx     out  current step
//   step_onehot  out  one-hot of step_idx while not idle, else 0
//   playing      out  high while in PLAY
//   done         out  1-cycle pulse at end of a one-shot pass
//   audio_out    out  square-wave tone
module step_sequencer #(
  parameter int STEPS      = 8,
  parameter int STEP_TICKS = 6250000,
  parameter int GATE_TICKS = 5000000,
  parameter int TONE_SHIFT = 0,
  localparam int AW        = (STEPS > 2) ? $clog2(STEPS) : 1
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             play,
  input  logic             stop,
  input  logic             loop_mode,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       wr_note,
  input  logic             wr_rest,
  output logic [AW-1:0]    step_idx,
  output logic [STEPS-1:0] step_onehot,
  output logic             playing,
  output logic             done,
  output logic             audio_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam int TW = $clog2(STEP_TICKS);
  localparam int LT = STEP_TICKS - 1;
  localparam int LS = STEPS - 1;
  localparam int GT = GATE_TICKS;
  localparam logic [TW-1:0] LAST_TICK = LT[TW-1:0];
  localparam logic [AW-1:0] LAST_STEP = LS[AW-1:0];
  localparam logic [TW:0]   GATE_LIM  = GT[TW:0];

  logic [1:0]             state;
  logic [TW-1:0]          tick;
  logic [16:0]            tone_cnt;
  logic                   tone_q;
  logic [2:0]             cur_note;
  logic                   cur_rest;
  logic [STEPS-1:0][2:0]  note_mem;
  logic [STEPS-1:0]       rest_mem;

  logic [AW-1:0] nxt_step;
  logic [16:0]   base, half;
  logic          last_tick, sounding, tone_run;

  assign nxt_step  = step_idx + 1'b1;
  assign last_tick = (tick == LAST_TICK);
  assign sounding  = (state == PLAY) && ({1'b0, tick} < GATE_LIM) && !cur_rest;
  // Tone keeps running only if the next cycle is the same step, still in PLAY;
  // every other case (boundary, pause, stop, not sounding) restarts it silent.
  assign tone_run  = sounding && !stop && !play && !last_tick;

  // Half-period table, C4..C5
  always_comb begin
    base = 17'd95556;
    case (cur_note)
      3'd0: base = 17'd95556;
      3'd1: base = 17'd85131;
      3'd2: base = 17'd75843;
      3'd3: base = 17'd71586;
      3'd4: base = 17'd63776;
      3'd5: base = 17'd56818;
      3'd6: base = 17'd50619;
      3'd7: base = 17'd47778;
      default: base = 17'd95556;
    endcase
    half = base >> TONE_SHIFT;
    if (half == 17'd0) half = 17'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state    <= IDLE;
      step_idx <= '0;
      tick     <= '0;
      tone_cnt <= '0;
      tone_q   <= 1'b0;
      done     <= 1'b0;
      cur_note <= 3'd0;
      cur_rest <= 1'b1;
      note_mem <= '0;
      rest_mem <= '1;
    end else begin
      done <= 1'b0;

      if (wr_en && (int'(wr_addr) < STEPS)) begin
        note_mem[wr_addr] <= wr_note;
        rest_mem[wr_addr] <= wr_rest;
      end

      if (stop) begin
        state    <= IDLE;
        step_idx <= '0;
        tick     <= '0;
      end else begin
        case (state)
          IDLE: if (play) begin
            state    <= PLAY;
            step_idx <= '0;
            tick     <= '0;
            cur_note <= note_mem[0];
            cur_rest <= rest_mem[0];
          end
          PLAY: begin
            if (play) begin
              state <= PAUSE;               // tick frozen at its current value
            end else if (last_tick) begin
              tick <= '0;
              if (step_idx == LAST_STEP) begin
                step_idx <= '0;
                if (loop_mode) begin
                  cur_note <= note_mem[0];
                  cur_rest <= rest_mem[0];
                end else begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              end else begin
                step_idx <= nxt_step;
                cur_note <= note_mem[nxt_step];
                cur_rest <= rest_mem[nxt_step];
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          PAUSE: if (play) state <= PLAY;
          default: state <= IDLE;
        endcase
      end

      if (tone_run) begin
        if (tone_cnt == half - 17'd1) begin
          tone_cnt <= '0;
          tone_q   <= ~tone_q;
        end else begin
          tone_cnt <= tone_cnt + 17'd1;
        end
      end else begin
        tone_cnt <= '0;
        tone_q   <= 1'b0;
      end
    end
  end

  // Gate with sounding so the pin drops in the very cycle the window closes.
  assign audio_out = tone_q && sounding;
  assign playing   = (state == PLAY);

  always_comb begin
    step_onehot = '0;
    if (state != IDLE) step_onehot[step_idx] = 1'b1;
  end

endmodule
